gshare_predictor: RTL
=====================

# gshare_predictor

Global-history branch direction predictor that answers the prediction requests raised by the IF and ID stages and absorbs branch outcomes resolved by the EX-stage branch unit. During decode of a conditional branch it returns a taken/untaken guess in the same cycle, so IF can redirect to the branch target with no bubble. It also returns the table index it consulted; the pipeline carries that index to EX and hands it back with the resolved outcome. Training is non-speculative: only resolved branches update history and counters.

## Interface
- `INDEX_BITS`, default 10: PHT has 2^INDEX_BITS two-bit counters; the GHR is also INDEX_BITS wide.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_en` in 1: decode-stage instruction is a conditional branch.
- `pred_pc` in 32: PC of that branch.
- `gshare_taken` out 1: prediction, combinational.
- `pred_index` out INDEX_BITS: index used for the prediction, combinational.
- `update_en` in 1: EX resolved a conditional branch this cycle.
- `update_index` in INDEX_BITS: `pred_index` carried with the branch.
- `update_taken` in 1: actual outcome.
- `update_approx` in 1: prediction that was made (`approximation`).
- `busy` out 1: table clear in progress.
- `stat_branches` out 32: resolved-branch count.
- `stat_mispred` out 32: misprediction count.

## Operation
- Lookup index = `pred_pc[INDEX_BITS-1:0] ^ ghr`. It is driven on `pred_index` regardless of `pred_en`.
- `gshare_taken` = `pht[index][1]` when `pred_en & ~busy`, else 0.
- Counter states, defined in the package:
  - `SNT`=00: strongly not-taken.
  - `WNT`=01: weakly not-taken.
  - `WT`=10: weakly taken.
  - `ST`=11: strongly taken.
- Update with `update_en & ~busy`:
  - `pht[update_index]` increments when taken and decrements when not taken.
  - Counters saturate at 11 and 00. No wrap.
  - `ghr <= {ghr[INDEX_BITS-2:0], update_taken}`.
  - `stat_branches` increments.
  - `stat_mispred` increments iff `update_taken != update_approx`.
  - Both statistics counters wrap modulo 2^32.
- Updates arriving while `busy` are dropped entirely: no PHT, GHR or statistics change.
- FSM states are CLEAR and READY.
  - `reset` enters CLEAR and sets `clear_idx` to 0, `ghr` to 0 and both statistics counters to 0.
  - In CLEAR, each cycle writes `WNT` to `pht[clear_idx]` and increments `clear_idx`.
  - When `clear_idx` reaches all-ones, the write completes and the FSM moves to READY on that edge.
  - READY is held until the next `reset`.
  - A `reset` mid-CLEAR restarts the clear from index 0.
- `busy` = (state == CLEAR).
- The PHT has no reset of its own. Its contents are defined only by the clear walk.

## Timing
- Values during and after reset:
  - `busy` is 1 from the first edge with `reset` high.
  - `gshare_taken` is 0.
  - `stat_branches` and `stat_mispred` are 0.
  - `ghr` is 0.
  - `pred_index` = `pred_pc[INDEX_BITS-1:0]`.
- The clear lasts exactly 2^INDEX_BITS cycles after `reset` deasserts. `busy` falls on the edge that writes the last entry.
- Lookup latency is 0 cycles: asynchronous PHT read, GHR read as a register.
- Updates take effect at the next rising edge.
- A lookup in the same cycle as an update sees the pre-update counter and pre-update GHR. There is no write-to-read bypass.
- One update per cycle at most. `update_en` is expected to be a single-cycle pulse per branch.
- Stall independence: the block does not see `stall`. A repeated lookup of the same PC while stalled returns the same result unless an update lands in between.

## Structure
- The package holds:
  - the counter-state constants `SNT/WNT/WT/ST`;
  - a function `sat_next(state, taken)` returning the next 2-bit counter value;
  - the default `INDEX_BITS`.
- Sub-module `gshare_pht`, a 2^INDEX_BITS x 2 distributed RAM:
  - one asynchronous read port;
  - one synchronous write port.
- Write-port mux: the clear-walk write has priority; otherwise the training write.
- The FSM, GHR and statistics counters live in the top module.

## Test plan
- Clear walk: with INDEX_BITS=4, pulse `reset` for 1 cycle, then hold `pred_en=1`, `pred_pc=0`.
  - `busy` stays high for exactly 16 cycles and `gshare_taken=0` throughout.
  - After the clear, `gshare_taken=0` (WNT) and `pred_index=0`.
- Training to taken: 2 updates at index 5 with `taken=1`, `approx=0`, separated by idle cycles.
  - Counter goes 01→10→11.
  - `ghr=0b0011`.
  - A lookup with `pred_pc=5^3=6` returns `gshare_taken=1`.
  - `stat_branches=2`, `stat_mispred=2`.
- Saturation: 5 taken updates to one index, then 1 not-taken.
  - Counter reads 11 after the taken updates, then 10 after the not-taken.
  - Prediction is still taken.
- Same-cycle hazard: a lookup and an update to the same index in one cycle.
  - The lookup returns the old counter and old-GHR index.
  - The next cycle reflects both changes.
- Reset mid-clear: assert `reset` at clear cycle 7, then deassert.
  - `busy` lasts a full 2^INDEX_BITS cycles from the deassert.
  - Statistics counters are 0.
- Dropped update: `update_en` during `busy`.
  - Afterwards `ghr=0`, `stat_branches=0`, and the PHT is all WNT.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - shared constants and counter helper for the gshare predictor
package gshare_predictor_pkg;

  localparam int DEFAULT_INDEX_BITS = 10;

  // Two-bit saturating counter states; bit 1 is the taken/not-taken guess.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } fsm_state_t;

  // Next counter value: step towards the outcome, pinned at both ends.
  function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
    logic [1:0] next;
    next = state;
    if (taken) begin
      if (state != ST) next = state + 2'b01;
    end else begin
      if (state != SNT) next = state - 2'b01;
    end
    return next;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// rtl/gshare_predictor_pht.sv - pattern history table, async lookup, sync read-modify-write
module gshare_pht
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                  clock,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic                  wr_clear,
  input  logic                  wr_taken,
  input  logic [INDEX_BITS-1:0] wr_index
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [1:0] mem [DEPTH];

  // Lookup port: no bypass, so a same-cycle write is not visible here.
  assign rd_ctr = mem[rd_index];

  // Write port: a clear forces WNT, otherwise the entry steps towards the outcome.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_index] <= wr_clear ? WNT : sat_next(mem[wr_index], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with clear walk, GHR and statistics
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pred_en,
  input  logic [31:0]           pred_pc,
  output logic                  gshare_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_approx,
  output logic                  busy,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispred
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
  localparam logic [INDEX_BITS-1:0] IDX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

  fsm_state_t            state;
  logic [INDEX_BITS-1:0] clear_idx;
  logic [INDEX_BITS-1:0] ghr;
  logic [1:0]            lookup_ctr;
  logic                  train_en;
  logic                  pht_wr_en;
  logic [INDEX_BITS-1:0] pht_wr_index;
  logic                  unused_pc_bits;

  // Only the low PC bits hash into the table.
  assign unused_pc_bits = ^pred_pc[31:INDEX_BITS];

  assign busy         = (state == CLEAR);
  assign pred_index   = pred_pc[INDEX_BITS-1:0] ^ ghr;
  assign gshare_taken = pred_en & ~busy & lookup_ctr[1];
  assign train_en     = update_en & ~busy;

  // Clear walk owns the write port while busy; training only gets it in READY.
  assign pht_wr_en    = busy | train_en;
  assign pht_wr_index = busy ? clear_idx : update_index;

  gshare_pht #(
    .INDEX_BITS(INDEX_BITS)
  ) u_pht (
    .clock    (clock),
    .rd_index (pred_index),
    .rd_ctr   (lookup_ctr),
    .wr_en    (pht_wr_en),
    .wr_clear (busy),
    .wr_taken (update_taken),
    .wr_index (pht_wr_index)
  );

  // Clear FSM: walk every entry once after reset, then stay READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else if (state == CLEAR) begin
      clear_idx <= clear_idx + IDX_ONE;
      if (clear_idx == LAST_IDX) begin
        state <= READY;
      end
    end
  end

  // Global history: shift in each resolved outcome accepted outside the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr <= '0;
    end else if (train_en) begin
      ghr <= {ghr[INDEX_BITS-2:0], update_taken};
    end
  end

  // Statistics: count resolved branches and wrong guesses, wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (train_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (update_taken != update_approx) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

endmodule
